w_grf: RTL and testbench

Write-back-stage register file for the five-stage MIPS pipeline. Consumes the W-stage pipeline register outputs (PC, RegWrite, MemtoReg, A3, ALU result, DM read data, T_new) and selects the write-back value. Commits that value into a 32×32 general register file and serves the two D-stage read ports, with write-to-read bypass. Also drives the W-stage forwarding source for the hazard unit.

---
 rtl/w_grf_if.sv | 27 ++
 rtl/w_grf.sv | 59 +++++
 tb/tb_w_grf.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/w_grf_if.sv
// W-stage to register-file bundle: write-back inputs, D-stage read ports and the W forwarding source.
// The master side is the pipeline; the slave side is the register file.
interface w_grf_if;
  logic [31:0] W_PC;
  logic [1:0]  W_T_new;
  logic        W_RegWrite;
  logic [1:0]  W_MemtoReg;
  logic [4:0]  W_A3;
  logic [31:0] W_ALU_C;
  logic [31:0] W_DM_RD;
  logic [4:0]  D_A1;
  logic [4:0]  D_A2;
  logic [31:0] D_RD1;
  logic [31:0] D_RD2;
  logic [31:0] W_WD;
  logic        W_fwd_valid;

  modport master (
    output W_PC, W_T_new, W_RegWrite, W_MemtoReg, W_A3, W_ALU_C, W_DM_RD, D_A1, D_A2,
    input  D_RD1, D_RD2, W_WD, W_fwd_valid
  );

  modport slave (
    input  W_PC, W_T_new, W_RegWrite, W_MemtoReg, W_A3, W_ALU_C, W_DM_RD, D_A1, D_A2,
    output D_RD1, D_RD2, W_WD, W_fwd_valid
  );
endinterface

// File: rtl/w_grf.sv
// Write-back stage register file: W data mux, 32x32 GPRs with $0 hardwired, same-cycle W->D bypass.
// Define W_GRF_DISPLAY_EN to log every committed write in simulation.
module w_grf #(
  parameter logic [31:0] PC8_OFFSET = 32'd8
) (
  input logic clk,
  input logic reset,
  w_grf_if.slave bus
);

  logic [31:0] gr [32];
  logic [31:0] wd;
  logic        we;

  always_comb begin
    wd = '0;
    case (bus.W_MemtoReg)
      2'd0:    wd = bus.W_ALU_C;
      2'd1:    wd = bus.W_DM_RD;
      2'd2:    wd = bus.W_PC + PC8_OFFSET;
      default: wd = '0;
    endcase
  end

  assign we              = bus.W_RegWrite && (bus.W_A3 != 5'd0);
  assign bus.W_WD        = wd;
  assign bus.W_fwd_valid = we && (bus.W_T_new == 2'd0);

  // gr[0] is cleared by reset and never selected for a write since we excludes A3 == 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) gr[i] <= '0;
    end else if (we) begin
      gr[bus.W_A3] <= wd;
    end
  end

  always_comb begin
    bus.D_RD1 = '0;
    if (bus.D_A1 == 5'd0)                 bus.D_RD1 = '0;
    else if (we && (bus.D_A1 == bus.W_A3)) bus.D_RD1 = wd;
    else                                   bus.D_RD1 = gr[bus.D_A1];
  end

  always_comb begin
    bus.D_RD2 = '0;
    if (bus.D_A2 == 5'd0)                 bus.D_RD2 = '0;
    else if (we && (bus.D_A2 == bus.W_A3)) bus.D_RD2 = wd;
    else                                   bus.D_RD2 = gr[bus.D_A2];
  end

`ifdef W_GRF_DISPLAY_EN
  always @(posedge clk) begin
    if (reset && we) $display("@%h: $%d <= %h", bus.W_PC, bus.W_A3, wd);
  end
`else
`endif

endmodule

// File: tb/tb_w_grf.sv
// Scoreboard bench for w_grf: expected values are queued when stimulus is driven and popped when sampled.
module tb_w_grf;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] exp_q [$];
  logic [31:0] exp_v;

  w_grf_if bus ();

  w_grf #(.PC8_OFFSET(32'd8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; outputs are sampled well before the next one.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.W_RegWrite = 1'b0;
    bus.W_MemtoReg = 2'd0;
    bus.W_A3       = 5'd0;
    bus.W_T_new    = 2'd0;
    bus.W_ALU_C    = '0;
    bus.W_DM_RD    = '0;
    bus.W_PC       = '0;
  endtask

  task automatic drive_alu_write(input logic [4:0] a3, input logic [31:0] val);
    bus.W_RegWrite = 1'b1;
    bus.W_MemtoReg = 2'd0;
    bus.W_A3       = a3;
    bus.W_ALU_C    = val;
    bus.W_T_new    = 2'd0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    bus.D_A1 = 5'd5;
    bus.D_A2 = 5'd6;
    // A write presented across an edge while reset is low must be dropped.
    drive_alu_write(5'd6, 32'h6666);
    step();
    idle();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (bus.W_fwd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_fwd got %b want 0", bus.W_fwd_valid); end
    checks++;
    if (bus.W_WD !== exp_v) begin errors++; $display("[TB] FAIL reset_wd got %h want %h", bus.W_WD, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (bus.D_RD2 !== exp_v) begin errors++; $display("[TB] FAIL reset_drop got %h want %h", bus.D_RD2, exp_v); end
    @(negedge clk);
    reset = 1'b1;
    step();
    drive_alu_write(5'd5, 32'h1234);
    step();
    idle();
    exp_q.push_back(32'h1234);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (bus.D_RD1 !== exp_v) begin errors++; $display("[TB] FAIL reset_pre got %h want %h", bus.D_RD1, exp_v); end
    #1;
    reset = 1'b0;
    exp_q.push_back(32'h0);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (bus.D_RD1 !== exp_v) begin errors++; $display("[TB] FAIL reset_async got %h want %h", bus.D_RD1, exp_v); end
    @(negedge clk);
    reset = 1'b1;
    step();
    drive_alu_write(5'd5, 32'hABCD);
    step();
    idle();
    exp_q.push_back(32'hABCD);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (bus.D_RD1 !== exp_v) begin errors++; $display("[TB] FAIL reset_after got %h want %h", bus.D_RD1, exp_v); end
  endtask

  task automatic test_mux();
    logic [31:0] want;
    bus.D_A1 = 5'd31;
    bus.D_A2 = 5'd0;
    for (int m = 0; m < 4; m++) begin
      bus.W_RegWrite = 1'b1;
      bus.W_MemtoReg = m[1:0];
      bus.W_A3       = 5'd31;
      bus.W_ALU_C    = 32'h11;
      bus.W_DM_RD    = 32'h22;
      bus.W_PC       = 32'h3000;
      bus.W_T_new    = 2'd0;
      case (m)
        0: want = 32'h11;
        1: want = 32'h22;
        2: want = 32'h3008;
        default: want = 32'h0;
      endcase
      exp_q.push_back(want);
      exp_q.push_back(want);
      #1;
      exp_v = exp_q.pop_front(); checks++;
      if (bus.W_WD !== exp_v) begin errors++; $display("[TB] FAIL mux_wd sel=%0d got %h want %h", m, bus.W_WD, exp_v); end
      checks++;
      if (bus.W_fwd_valid !== 1'b1) begin errors++; $display("[TB] FAIL mux_fwd sel=%0d got %b want 1", m, bus.W_fwd_valid); end
      step();
      idle();
      #1;
      exp_v = exp_q.pop_front(); checks++;
      if (bus.D_RD1 !== exp_v) begin errors++; $display("[TB] FAIL mux_rb sel=%0d got %h want %h", m, bus.D_RD1, exp_v); end
      step();
    end
    // PC+offset wraps modulo 2^32.
    bus.W_RegWrite = 1'b1;
    bus.W_MemtoReg = 2'd2;
    bus.W_A3       = 5'd30;
    bus.W_PC       = 32'hFFFF_FFFC;
    exp_q.push_back(32'h4);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (bus.W_WD !== exp_v) begin errors++; $display("[TB] FAIL mux_wrap got %h want %h", bus.W_WD, exp_v); end
    step();
    idle();
  endtask

  task automatic test_bypass();
    drive_alu_write(5'd8, 32'h5555);
    step();
    idle();
    bus.D_A1 = 5'd8;
    bus.D_A2 = 5'd8;
    #1;
    drive_alu_write(5'd8, 32'hDEAD);
    exp_q.push_back(32'hDEAD);
    exp_q.push_back(32'hDEAD);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (bus.D_RD1 !== exp_v) begin errors++; $display("[TB] FAIL bypass_rd1 got %h want %h", bus.D_RD1, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (bus.D_RD2 !== exp_v) begin errors++; $display("[TB] FAIL bypass_rd2 got %h want %h", bus.D_RD2, exp_v); end
    // Port 2 reads a different register while port 1 bypasses.
    bus.D_A2 = 5'd31;
    exp_q.push_back(32'h0);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (bus.D_RD2 !== exp_v) begin errors++; $display("[TB] FAIL bypass_other got %h want %h", bus.D_RD2, exp_v); end
    step();
    idle();
  endtask

  task automatic test_zero();
    bus.D_A1 = 5'd0;
    drive_alu_write(5'd0, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    #1;
    checks++;
    if (bus.W_fwd_valid !== 1'b0) begin errors++; $display("[TB] FAIL zero_fwd got %b want 0", bus.W_fwd_valid); end
    exp_v = exp_q.pop_front(); checks++;
    if (bus.D_RD1 !== exp_v) begin errors++; $display("[TB] FAIL zero_pre got %h want %h", bus.D_RD1, exp_v); end
    step();
    idle();
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (bus.D_RD1 !== exp_v) begin errors++; $display("[TB] FAIL zero_post got %h want %h", bus.D_RD1, exp_v); end
  endtask

  task automatic test_t_new();
    bus.D_A1 = 5'd3;
    drive_alu_write(5'd3, 32'h77);
    bus.W_T_new = 2'd1;
    exp_q.push_back(32'h77);
    #1;
    checks++;
    if (bus.W_fwd_valid !== 1'b0) begin errors++; $display("[TB] FAIL tnew_fwd got %b want 0", bus.W_fwd_valid); end
    step();
    idle();
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (bus.D_RD1 !== exp_v) begin errors++; $display("[TB] FAIL tnew_commit got %h want %h", bus.D_RD1, exp_v); end
  endtask

  task automatic test_back_to_back();
    bus.D_A1 = 5'd4;
    drive_alu_write(5'd4, 32'h1);
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h2);
    exp_q.push_back(32'h2);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (bus.D_RD1 !== exp_v) begin errors++; $display("[TB] FAIL b2b_first got %h want %h", bus.D_RD1, exp_v); end
    step();
    drive_alu_write(5'd4, 32'h2);
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (bus.D_RD1 !== exp_v) begin errors++; $display("[TB] FAIL b2b_second got %h want %h", bus.D_RD1, exp_v); end
    step();
    idle();
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if (bus.D_RD1 !== exp_v) begin errors++; $display("[TB] FAIL b2b_stored got %h want %h", bus.D_RD1, exp_v); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus.D_A1 = 5'd0;
    bus.D_A2 = 5'd0;
    idle();
    test_reset();
    test_mux();
    test_bypass();
    test_zero();
    test_t_new();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL scoreboard_left got %0d want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
